decoder_3to8_strobe: RTL and testbench
======================================

# decoder_3to8_strobe

Registered 3-to-8 decoder with a valid/ready input handshake, the inverse of the team's 8:3 encoder. It accepts a 3-bit code, drives the matching one-hot line of `y` for a programmable number of cycles, then enforces a programmable idle gap. It is used to fire one-of-eight strobes into downstream blocks from a compact code bus.

## Interface
- `HOLD_CYCLES`, default 4: cycles each one-hot strobe is held; legal range ≥1.
- `GAP_CYCLES`, default 1: forced all-zero cycles after each strobe; legal range ≥0.
- `clk`  input  1: single clock; all state updates on rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `en`  input  1: block enable; low aborts any strobe and blocks acceptance.
- `in_valid`  input  1: `a` holds a code to decode.
- `in_ready`  output  1: block can accept; combinational, equals `en && state==IDLE`.
- `a`  input  3: code to decode, 0..7.
- `y`  output  8: registered one-hot output, `y = 8'b1 << a_latched` while driving, else 0.
- `busy`  output  1: registered, high in DRIVE or GAP.
- `done`  output  1: registered, one-cycle pulse when a strobe completes normally.

## Operation
- FSM states: IDLE, DRIVE, GAP. A down-counter is sized `$clog2(max(HOLD_CYCLES,GAP_CYCLES)+1)`, minimum 1 bit.
- Reset (async assert): state=IDLE, `y`=0, `busy`=0, `done`=0, counter=0, latched code=0. Deassertion takes effect at the next edge.
- IDLE: if `in_valid && in_ready` at an edge, latch `a`, load counter=HOLD_CYCLES-1, go to DRIVE, set `y`=one-hot(a) and `busy`=1.
- DRIVE: hold `y`. If counter≠0, decrement. If counter==0: set `y`=0 and `done`=1; if GAP_CYCLES>0, go to GAP with counter=GAP_CYCLES-1; otherwise go to IDLE with `busy`=0.
- GAP: `y`=0. Decrement until counter==0, then go to IDLE with `busy`=0.
- `done` is high for exactly the one cycle after the last DRIVE cycle. It is 0 in every other cycle.
- `en` low in any state: at the next edge, state=IDLE, `y`=0, `busy`=0, `done`=0 (abort, no done). `in_ready`=0 while `en` is low.
- `in_valid` while not ready: ignored. The source must hold `a`/`in_valid` stable until a handshake occurs. `a` changing during DRIVE does not affect `y`.
- All 8 codes are legal. There is no error output.

## Timing
- Handshake at edge k: `y` is one-hot from after edge k through edge k+HOLD_CYCLES. That is exactly HOLD_CYCLES cycles of latency-1 registered output.
- `done` is high for the cycle after edge k+HOLD_CYCLES.
- `in_ready` is high again after edge k+HOLD_CYCLES+GAP_CYCLES, so the next handshake can occur no earlier than edge k+HOLD_CYCLES+GAP_CYCLES+1.
- Maximum throughput is one code per HOLD_CYCLES+GAP_CYCLES+1 cycles.
- `y` never has more than one bit set, and two strobes are never adjacent without at least the IDLE cycle between them.
- Asynchronous reset during DRIVE clears `y` immediately, without waiting for a clock edge.

## Structure
- Shared package `decoder_pkg`: `CODE_W=3`, `OUT_W=8`, and the state typedef `dec_state_t` {IDLE, DRIVE, GAP}.
- One sub-module, `onehot_dec`, a combinational CODE_W→OUT_W one-hot decoder. Its output is registered into `y` by the parent on the handshake.

## Test plan
- Reset: with `rst_n`=0 and `en`=1, `y`=0, `busy`=0, `done`=0, `in_ready`=1. The async assert mid-DRIVE (a=3) drops `y` from 00001000 to 0 before the next edge.
- Sweep with defaults: handshake a=0..7 in turn. `y` must read 00000001, 00000010, …, 10000000, each for exactly 4 cycles, followed by a 1-cycle `done` and 1 gap cycle. The next accept comes 6 cycles after the previous one.
- Backpressure: accept a=5, then present a=2 with `in_valid` held. `in_ready` stays 0 for 5 cycles, `y`=00100000 for 4 cycles, and a=2 is accepted in the first IDLE cycle, giving `y`=00000100.
- Abort: accept a=6, then drop `en` in the 2nd DRIVE cycle. `y`=0 and `busy`=0 at the next edge, with no `done` pulse. After `en` returns to 1, `in_ready`=1.
- Minimal parameters (HOLD_CYCLES=1, GAP_CYCLES=0), `in_valid` held with a=7. `y`=10000000 for 1 cycle, then 0 for 1 cycle, repeating. `done` pulses every 2 cycles.
- Mid-strobe input change: accept a=1, then change `a` to 4 during DRIVE with `in_valid`=0. `y` stays 00000010 for all 4 cycles.

Source files
------------

// File: rtl/decoder_pkg.sv
// decoder_pkg: shared widths and FSM state type for the 3-to-8 strobe decoder
package decoder_pkg;
  localparam int CODE_W = 3;
  localparam int OUT_W = 8;
  typedef enum logic [1:0] {IDLE, DRIVE, GAP} dec_state_t;
endpackage

// File: rtl/onehot_dec.sv
// onehot_dec: combinational code to one-hot decoder
import decoder_pkg::*;
module onehot_dec (
  input  logic [CODE_W-1:0] a,
  output logic [OUT_W-1:0]  y
);
  assign y = OUT_W'(1) << a;
endmodule

// File: rtl/decoder_3to8_strobe.sv
// decoder_3to8_strobe: handshaked code in, one-hot strobe held for HOLD_CYCLES, then GAP_CYCLES idle
import decoder_pkg::*;
module decoder_3to8_strobe #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] a,
  output logic [OUT_W-1:0]  y,
  output logic              busy,
  output logic              done
);
  localparam int MX = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MX + 1) < 1 ? 1 : $clog2(MX + 1);
  localparam int GL = GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0;
  dec_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CODE_W-1:0] code, code_n, sel;
  logic [OUT_W-1:0] dec, y_n;
  logic busy_n, done_n;
  assign in_ready = en && state == IDLE;
  assign sel = state == IDLE ? a : code;
  onehot_dec u_dec (.a(sel), .y(dec));
  // next-state and registered-output logic; en low forces an abort to IDLE
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    code_n = code;
    y_n = y;
    busy_n = busy;
    done_n = 1'b0;
    if (!en) begin
      state_n = IDLE;
      y_n = '0;
      busy_n = 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          state_n = DRIVE;
          code_n = a;
          cnt_n = CW'(HOLD_CYCLES - 1);
          y_n = dec;
          busy_n = 1'b1;
        end
        DRIVE: if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
          y_n = dec;
        end else begin
          y_n = '0;
          done_n = 1'b1;
          state_n = GAP_CYCLES > 0 ? GAP : IDLE;
          cnt_n = CW'(GL);
          busy_n = GAP_CYCLES > 0;
        end
        GAP: if (cnt != '0) cnt_n = cnt - CW'(1);
        else begin
          state_n = IDLE;
          busy_n = 1'b0;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  // state and output registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      code <= '0;
      y <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      code <= code_n;
      y <= y_n;
      busy <= busy_n;
      done <= done_n;
    end
  end
endmodule

// File: tb/tb_decoder_3to8_strobe.sv
// tb_decoder_3to8_strobe: directed checks of default and minimal-parameter decoders
module tb_decoder_3to8_strobe;
  logic clk = 1'b0, rst_n = 1'b0;
  logic en = 1'b1, in_valid = 1'b0, in_ready, busy, done;
  logic [2:0] a = '0;
  logic [7:0] y;
  logic en2 = 1'b1, v2 = 1'b0, r2, b2, d2;
  logic [2:0] a2 = '0;
  logic [7:0] y2;
  int vec = 0, errs = 0;

  decoder_3to8_strobe dut (.clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .y(y), .busy(busy), .done(done));
  decoder_3to8_strobe #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) dut_min (.clk(clk), .rst_n(rst_n),
    .en(en2), .in_valid(v2), .in_ready(r2), .a(a2), .y(y2), .busy(b2), .done(d2));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (!in_ready && n < 20) begin step(); n++; end
    vec++;
    if (!in_ready) begin errs++; $display("FAIL drain: in_ready stuck at %b, want 1", in_ready); end
  endtask

  task automatic test_reset();
    #2;
    vec++; if (y !== 8'h00) begin errs++; $display("FAIL reset y: got %b want 00000000", y); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL reset busy: got %b want 0", busy); end
    vec++; if (done !== 1'b0) begin errs++; $display("FAIL reset done: got %b want 0", done); end
    vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) begin
      vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL sweep ready %0d: got %b want 1", i, in_ready); end
      a = 3'(i);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      exp = 8'h01 << i;
      for (int c = 0; c < 4; c++) begin
        vec++; if (y !== exp || busy !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) begin
          errs++; $display("FAIL sweep drive %0d/%0d: y=%b busy=%b done=%b rdy=%b want y=%b busy=1 done=0 rdy=0", i, c, y, busy, done, in_ready, exp);
        end
        step();
      end
      vec++; if (y !== 8'h00 || done !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
        errs++; $display("FAIL sweep gap %0d: y=%b done=%b busy=%b rdy=%b want y=0 done=1 busy=1 rdy=0", i, y, done, busy, in_ready);
      end
      step();
      vec++; if (done !== 1'b0 || busy !== 1'b0) begin
        errs++; $display("FAIL sweep idle %0d: done=%b busy=%b want 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    a = 3'd5;
    in_valid = 1'b1;
    step();
    a = 3'd2;
    for (int c = 0; c < 5; c++) begin
      vec++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp ready %0d: got %b want 0", c, in_ready); end
      vec++; if (y !== (c < 4 ? 8'b0010_0000 : 8'h00)) begin
        errs++; $display("FAIL bp y %0d: got %b want %b", c, y, c < 4 ? 8'b0010_0000 : 8'h00);
      end
      step();
    end
    vec++; if (in_ready !== 1'b1 || y !== 8'h00) begin errs++; $display("FAIL bp idle: rdy=%b y=%b want 1 00000000", in_ready, y); end
    step();
    in_valid = 1'b0;
    vec++; if (y !== 8'b0000_0100) begin errs++; $display("FAIL bp second y: got %b want 00000100", y); end
    drain();
  endtask

  task automatic test_abort();
    a = 3'd6;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    vec++; if (y !== 8'b0100_0000) begin errs++; $display("FAIL abort drive: got %b want 01000000", y); end
    en = 1'b0;
    step();
    vec++; if (y !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
      errs++; $display("FAIL abort: y=%b busy=%b done=%b rdy=%b want 0 0 0 0", y, busy, done, in_ready);
    end
    repeat (4) begin
      step();
      vec++; if (done !== 1'b0 || y !== 8'h00) begin errs++; $display("FAIL abort quiet: done=%b y=%b want 0 0", done, y); end
    end
    en = 1'b1;
    #1;
    vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL abort resume: rdy=%b want 1", in_ready); end
  endtask

  task automatic test_mid_change();
    a = 3'd1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = 3'd4;
    for (int c = 0; c < 4; c++) begin
      vec++; if (y !== 8'b0000_0010) begin errs++; $display("FAIL mid y %0d: got %b want 00000010", c, y); end
      step();
    end
    vec++; if (y !== 8'h00 || done !== 1'b1) begin errs++; $display("FAIL mid end: y=%b done=%b want 0 1", y, done); end
    drain();
  endtask

  task automatic test_async_reset();
    a = 3'd3;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    vec++; if (y !== 8'b0000_1000) begin errs++; $display("FAIL arst pre: got %b want 00001000", y); end
    #2 rst_n = 1'b0;
    #1;
    vec++; if (y !== 8'h00 || busy !== 1'b0) begin errs++; $display("FAIL arst: y=%b busy=%b want 0 0", y, busy); end
    rst_n = 1'b1;
    step();
    vec++; if (in_ready !== 1'b1 || y !== 8'h00) begin errs++; $display("FAIL arst after: rdy=%b y=%b want 1 0", in_ready, y); end
  endtask

  task automatic test_min_params();
    a2 = 3'd7;
    v2 = 1'b1;
    for (int r = 0; r < 4; r++) begin
      step();
      vec++; if (y2 !== 8'b1000_0000 || d2 !== 1'b0 || b2 !== 1'b1 || r2 !== 1'b0) begin
        errs++; $display("FAIL min drive %0d: y=%b done=%b busy=%b rdy=%b want 10000000 0 1 0", r, y2, d2, b2, r2);
      end
      step();
      vec++; if (y2 !== 8'h00 || d2 !== 1'b1 || b2 !== 1'b0 || r2 !== 1'b1) begin
        errs++; $display("FAIL min idle %0d: y=%b done=%b busy=%b rdy=%b want 0 1 0 1", r, y2, d2, b2, r2);
      end
    end
    v2 = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sweep();
    test_back_to_back();
    test_abort();
    test_mid_change();
    test_async_reset();
    test_min_params();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
